reverser: RTL and testbench
===========================

REVERSER -- requirements
Module: reverser

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 Port: in  input  WIDTH  data word to be conditionally bit-reversed.
REQ-005 Port: dir  input  1  1 = reverse bit order, 0 = pass through unchanged.
REQ-006 Port: in_valid  input  1  qualifies in/dir for capture this cycle.
REQ-007 Port: rev1  output  WIDTH  registered result word.
REQ-008 Port: out_valid  output  1  high for exactly the cycle(s) rev1 holds a result captured from a valid input.

Function
REQ-009 Reversal SHALL map result bit i to in[WIDTH-1-i] for all i in 0..WIDTH-1 when dir=1.
REQ-010 Pass-through SHALL map result bit i to in[i] when dir=0.
REQ-011 On a rising edge with rst=0 and in_valid=1, rev1 SHALL load the dir-selected result and out_valid SHALL go 1; latency exactly 1 cycle.
REQ-012 On a rising edge with rst=0 and in_valid=0, rev1 SHALL hold its previous value and out_valid SHALL go 0.
REQ-013 No back-pressure: every valid input SHALL be accepted; back-to-back valid inputs SHALL produce back-to-back outputs at full throughput.
REQ-014 dir SHALL be sampled only together with in when in_valid=1; dir changes while in_valid=0 SHALL have no effect.
REQ-015 Palindromic inputs (e.g. 8'b10011001) SHALL produce identical output for dir=0 and dir=1.
REQ-016 No X propagation: outputs SHALL be fully defined after the first reset.

Reset
REQ-017 When rst=1 at a rising edge, rev1 SHALL become all zeros and out_valid SHALL become 0, regardless of in_valid.
REQ-018 Reset SHALL take priority over a simultaneous valid input; that input is dropped.
REQ-019 The first valid input after rst deasserts SHALL be processed normally on the next edge.

Configuration
REQ-020 Macro REVERSER_PARITY_EN: when defined, an extra output port parity (output, 1 bit) SHALL be present, registered alongside rev1, equal to XOR of all bits of the captured result, reset to 0, held when in_valid=0.
REQ-021 Without REVERSER_PARITY_EN, the parity port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-022 Package reverser_pkg SHALL hold the default WIDTH constant and a bit-reverse function usable by other blocks.
REQ-023 A combinational sub-module bit_rev (WIDTH-parameterised, in -> out reversed) SHALL implement the reversal; reverser adds the dir mux and output registers.

Verification
REQ-024 rst=1 for 2 cycles with in_valid=1, in=8'hFF -> rev1=8'h00, out_valid=0.
REQ-025 in=8'b11110000, dir=1, in_valid=1 -> next cycle rev1=8'b00001111, out_valid=1.
REQ-026 in=8'b11110000, dir=0, in_valid=1 -> next cycle rev1=8'b11110000; then in_valid=0 -> rev1 holds 8'b11110000, out_valid=0.
REQ-027 Back-to-back 8'b00000001 (dir=1), 8'b10100000 (dir=1), 8'b01100000 (dir=0) -> consecutive outputs 8'b10000000, 8'b00000101, 8'b01100000 with out_valid=1 each cycle.
REQ-028 rst=1 coincident with in_valid=1, in=8'h0F, dir=1 -> rev1=8'h00, out_valid=0; no 8'hF0 appears afterwards.
REQ-029 With REVERSER_PARITY_EN, in=8'b00000111, dir=1 -> rev1=8'b11100000, parity=1; in=8'b00000011 -> parity=0.

Source files
------------

// File: rtl/reverser_pkg.sv
// Shared constants and helpers for the reverser block.
// Used by reverser and bit_rev; safe to import elsewhere.
package reverser_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH = 64;

  function automatic logic [MAX_WIDTH-1:0] bit_reverse(
    input logic [MAX_WIDTH-1:0] x,
    input int                   w
  );
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) r[i] = x[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/reverser_bit_rev.sv
// Purely combinational bit-order reversal.
// out[i] = in[WIDTH-1-i].
module bit_rev
  import reverser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign out[i] = in[WIDTH-1-i];
  end

endmodule

// File: rtl/reverser.sv
// Registered conditional bit reverser, 1-cycle latency.
// Optional parity output enabled by REVERSER_PARITY_EN.
module reverser
  import reverser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             dir,
  input  logic             in_valid,
  output logic [WIDTH-1:0] rev1,
`ifdef REVERSER_PARITY_EN
  output logic             parity,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] flipped;
  logic [WIDTH-1:0] result;

  bit_rev #(.WIDTH(WIDTH)) u_rev (
    .in  (in),
    .out (flipped)
  );

  assign result = dir ? flipped : in;

  always_ff @(posedge clk) begin
    if (rst) begin
      rev1      <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      rev1      <= result;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef REVERSER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)
      parity <= 1'b0;
    else if (in_valid)
      parity <= ^result;
  end
`endif

endmodule

// File: tb/tb_reverser.sv
// Self-checking bench for reverser against a behavioural model.
// Define REVERSER_PARITY_EN to also check the parity output.
module tb_reverser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in;
  logic         dir;
  logic         in_valid;
  logic [W-1:0] rev1;
  logic         out_valid;
`ifdef REVERSER_PARITY_EN
  logic         parity;
`endif

  int checks = 0;
  int fails  = 0;

  logic [W-1:0] m_rev;
  logic         m_valid;
  logic         m_par;

  always #5 clk = ~clk;

  reverser #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .dir       (dir),
    .in_valid  (in_valid),
    .rev1      (rev1),
`ifdef REVERSER_PARITY_EN
    .parity    (parity),
`endif
    .out_valid (out_valid)
  );

  function automatic logic [W-1:0] ref_rev(
    input logic [W-1:0] x
  );
    int unsigned v;
    int unsigned r;
    v = x;
    r = 0;
    for (int i = 0; i < W; i++)
      if ((v >> i) % 2 == 1) r += (1 << (W - 1 - i));
    return r[W-1:0];
  endfunction

  function automatic logic ref_par(input logic [W-1:0] x);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) n += x[i];
    return (n % 2) == 1;
  endfunction

  task automatic chk(
    input string tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rev1"}, 64'(rev1), 64'(m_rev));
    chk({tag, ".vld"}, 64'(out_valid), 64'(m_valid));
`ifdef REVERSER_PARITY_EN
    chk({tag, ".par"}, 64'(parity), 64'(m_par));
`endif
  endtask

  task automatic step(
    input logic         r,
    input logic [W-1:0] d,
    input logic         dr,
    input logic         v
  );
    @(negedge clk);
    rst = r;
    in = d;
    dir = dr;
    in_valid = v;
    @(posedge clk);
    #1;
    if (r) begin
      m_rev = '0;
      m_valid = 1'b0;
      m_par = 1'b0;
    end else if (v) begin
      m_rev = dr ? ref_rev(d) : d;
      m_valid = 1'b1;
      m_par = ref_par(m_rev);
    end else begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    in = '0;
    dir = 1'b0;
    in_valid = 1'b0;
    m_rev = '0;
    m_valid = 1'b0;
    m_par = 1'b0;

    step(1'b1, 8'hFF, 1'b1, 1'b1);
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    check_all("reset");
    chk("reset.lit", 64'(rev1), 64'h00);

    step(1'b0, 8'b11110000, 1'b1, 1'b1);
    check_all("rev_f0");
    chk("rev_f0.lit", 64'(rev1), 64'h0F);

    step(1'b0, 8'b11110000, 1'b0, 1'b1);
    check_all("pass_f0");
    step(1'b0, 8'h3C, 1'b1, 1'b0);
    check_all("hold");
    chk("hold.lit", 64'(rev1), 64'hF0);

    step(1'b0, 8'b00000001, 1'b1, 1'b1);
    chk("b2b0", 64'(rev1), 64'h80);
    chk("b2b0.v", 64'(out_valid), 64'd1);
    step(1'b0, 8'b10100000, 1'b1, 1'b1);
    chk("b2b1", 64'(rev1), 64'h05);
    chk("b2b1.v", 64'(out_valid), 64'd1);
    step(1'b0, 8'b01100000, 1'b0, 1'b1);
    chk("b2b2", 64'(rev1), 64'h60);
    chk("b2b2.v", 64'(out_valid), 64'd1);

    step(1'b1, 8'h0F, 1'b1, 1'b1);
    check_all("rst_pri");
    chk("rst_pri.lit", 64'(rev1), 64'h00);
    step(1'b0, 8'h0F, 1'b1, 1'b0);
    chk("no_f0", 64'(rev1), 64'h00);
    chk("no_f0.v", 64'(out_valid), 64'd0);

    step(1'b0, 8'b10011001, 1'b0, 1'b1);
    chk("pal0", 64'(rev1), 64'h99);
    step(1'b0, 8'b10011001, 1'b1, 1'b1);
    chk("pal1", 64'(rev1), 64'h99);

    step(1'b0, 8'h12, 1'b1, 1'b1);
    step(1'b0, 8'hAB, 1'b0, 1'b0);
    step(1'b0, 8'hCD, 1'b1, 1'b0);
    check_all("dir_idle");
    chk("dir_idle.lit", 64'(rev1), 64'h48);

`ifdef REVERSER_PARITY_EN
    step(1'b0, 8'b00000111, 1'b1, 1'b1);
    chk("par7.rev", 64'(rev1), 64'hE0);
    chk("par7", 64'(parity), 64'd1);
    step(1'b0, 8'b00000011, 1'b1, 1'b1);
    chk("par3", 64'(parity), 64'd0);
`endif

    for (int k = 0; k < 300; k++) begin
      step($urandom_range(15) == 0,
           W'($urandom),
           1'($urandom),
           $urandom_range(3) != 0);
      check_all("rand");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
